// File: rtl/sha_absorb_packer.sv
// SHA-3 absorb front end: packs an AXI-Stream message into rate-sized Keccak blocks
// with pad10*1 and the domain suffix. Define SHA_PACK_SHAKE_EN to add SHAKE128/256.
module sha_absorb_packer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic                    S_TVALID,
  output logic                    S_TREADY,
  input  logic                    S_TLAST,
  input  logic [1:0]              S_TID,
`ifdef SHA_PACK_SHAKE_EN
  input  logic                    S_TUSER,
`endif
  output logic [4:0][4:0][63:0]   Block,
  output logic                    Block_valid,
  input  logic                    Block_ready,
  output logic                    Block_first,
  output logic                    Block_last
);

  localparam int KEEP_W      = DATA_WIDTH / 8;
  localparam int CNT_W       = 8;
  localparam int STATE_BYTES = 200;

  typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [STATE_BYTES];
  logic [7:0]       mem_d [STATE_BYTES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             shake_q, shake_d;
  logic             msg_active_q, msg_active_d;
  logic             sent_q, sent_d;
  logic             pad_pend_q, pad_pend_d;
  logic             first_d, last_d;

  logic             shake_in;
  logic             accept;
  logic             first_beat;
  logic             shake_eff;
  logic             full;
  logic [CNT_W-1:0] rate_eff;
  logic [CNT_W-1:0] nbytes;
  logic [CNT_W-1:0] cnt_fill;
  logic [7:0]       suffix_eff;
  logic [7:0]       suffix_q;

`ifdef SHA_PACK_SHAKE_EN
  assign shake_in = S_TUSER;
`else
  assign shake_in = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] rate_of(input logic [1:0] tid, input logic shake);
    logic [CNT_W-1:0] r;
    case (tid)
      2'd0:    r = shake ? 8'd168 : 8'd144;
      2'd1:    r = 8'd136;
      2'd2:    r = 8'd104;
      default: r = 8'd72;
    endcase
    return r;
  endfunction

  assign S_TREADY    = ARESETn && (state_q == FILL);
  assign Block_valid = (state_q == EMIT);
  assign accept      = S_TREADY && S_TVALID;

  // TID/TUSER only matter on the opening beat; later beats reuse the latched values.
  assign first_beat = !msg_active_q;
  assign rate_eff   = first_beat ? rate_of(S_TID, shake_in) : rate_q;
  assign shake_eff  = first_beat ? shake_in : shake_q;
  assign suffix_eff = shake_eff ? 8'h1F : 8'h06;
  assign suffix_q   = shake_q ? 8'h1F : 8'h06;

  always_comb begin
    nbytes = '0;
    for (int j = 0; j < KEEP_W; j++) nbytes = nbytes + CNT_W'(S_TKEEP[j]);
  end

  assign cnt_fill = cnt_q + nbytes;
  assign full     = (cnt_fill == rate_eff);

  // NOTE: next-state logic uses blocking assignments, and every variable gets its
  // hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    cnt_d        = cnt_q;
    rate_d       = rate_q;
    shake_d      = shake_q;
    msg_active_d = msg_active_q;
    sent_d       = sent_q;
    pad_pend_d   = pad_pend_q;
    first_d      = Block_first;
    last_d       = Block_last;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (first_beat) begin
            rate_d  = rate_eff;
            shake_d = shake_eff;
          end
          for (int j = 0; j < KEEP_W; j++) begin
            if (S_TKEEP[j]) mem_d[cnt_q + CNT_W'(j)] = S_TDATA[8*j +: 8];
          end
          cnt_d        = cnt_fill;
          msg_active_d = !S_TLAST;
          if (full) begin
            // An exactly full final block still needs a separate all-padding block.
            state_d    = EMIT;
            first_d    = !sent_q;
            last_d     = 1'b0;
            pad_pend_d = S_TLAST;
          end else if (S_TLAST) begin
            mem_d[cnt_fill] = suffix_eff;
            mem_d[rate_eff - 8'd1] = (cnt_fill == rate_eff - 8'd1) ?
                                     (suffix_eff | 8'h80) : 8'h80;
            state_d = EMIT;
            first_d = !sent_q;
            last_d  = 1'b1;
          end
        end
      end

      PAD: begin
        mem_d[0]             = suffix_q;
        mem_d[rate_q - 8'd1] = 8'h80;
        first_d              = 1'b0;
        last_d               = 1'b1;
        state_d              = EMIT;
      end

      EMIT: begin
        if (Block_ready) begin
          for (int i = 0; i < STATE_BYTES; i++) mem_d[i] = 8'h00;
          cnt_d      = '0;
          state_d    = pad_pend_q ? PAD : FILL;
          pad_pend_d = 1'b0;
          sent_d     = !Block_last;
          first_d    = 1'b0;
          last_d     = 1'b0;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      rate_q       <= 8'd144;
      shake_q      <= 1'b0;
      msg_active_q <= 1'b0;
      sent_q       <= 1'b0;
      pad_pend_q   <= 1'b0;
      Block_first  <= 1'b0;
      Block_last   <= 1'b0;
      // NOTE: the block store is reset as well, so Block reads 0 after reset and an
      // aborted message leaves no stale bytes in the next block.
      for (int i = 0; i < STATE_BYTES; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rate_q       <= rate_d;
      shake_q      <= shake_d;
      msg_active_q <= msg_active_d;
      sent_q       <= sent_d;
      pad_pend_q   <= pad_pend_d;
      Block_first  <= first_d;
      Block_last   <= last_d;
      mem_q        <= mem_d;
    end
  end

  // Byte k lives in lane k/8 (little-endian), lane i at Block[i%5][i/5].
  for (genvar i = 0; i < 25; i++) begin : g_lane
    for (genvar b = 0; b < 8; b++) begin : g_byte
      assign Block[i%5][i/5][b*8 +: 8] = mem_q[i*8 + b];
    end
  end

endmodule
